// File: rtl/decode_hazard_regfile_pkg.sv
// Shared constants for the decode-stage register file and hazard unit.
package decode_hazard_regfile_pkg;

  localparam int DATA_W = 16;  // register and data width
  localparam int NREG   = 8;   // number of architectural registers
  localparam int IDX_W  = 3;   // register index width, log2(NREG)
  localparam int CNT_W  = 16;  // stall-cycle performance counter width

endpackage

// File: rtl/decode_hazard_regfile_rf8x16_bypass.sv
// 8 x 16 register file: one synchronous write port from WB and two
// combinational read ports. A read that hits the index being written in the
// same cycle returns the incoming write data.
module rf8x16_bypass
  import decode_hazard_regfile_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  rdIdx1,
  input  logic [IDX_W-1:0]  rdIdx2,
  input  logic [IDX_W-1:0]  wrIdx,
  input  logic [DATA_W-1:0] wrData,
  input  logic              wrEn,
  output logic [DATA_W-1:0] rdData1,
  output logic [DATA_W-1:0] rdData2
);

  logic [DATA_W-1:0] regs [NREG];

  // Storage update: reset clears every register, otherwise the WB write lands.
  // NOTE: this array is reset on purpose because software may read a register
  // before ever writing it and must see zero; a plain data RAM would skip the
  // reset so it can map onto memory macros.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        // NOTE: state is always updated with non-blocking assignments so every
        // flop samples pre-edge values regardless of statement order.
        regs[i] <= '0;
      end
    end else if (wrEn) begin
      regs[wrIdx] <= wrData;
    end
  end

  // Read ports with same-cycle write-through, so WB results reach ID at once.
  // NOTE: each output gets its array value first and is then overridden, so
  // every path assigns it and no latch is inferred.
  always_comb begin
    rdData1 = regs[rdIdx1];
    rdData2 = regs[rdIdx2];
    if (wrEn && (wrIdx == rdIdx1)) rdData1 = wrData;
    if (wrEn && (wrIdx == rdIdx2)) rdData2 = wrData;
  end

endmodule

// File: rtl/decode_hazard_regfile.sv
// Decode stage: register file operands for ID/EX, load-use hazard detection
// against the instruction in EX, stall/bubble controls and a saturating
// stall-cycle counter.
module decode_hazard_regfile
  import decode_hazard_regfile_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  rs,
  input  logic [IDX_W-1:0]  rt,
  input  logic              rsUsed,
  input  logic              rtUsed,
  input  logic [IDX_W-1:0]  wbWritereg,
  input  logic [DATA_W-1:0] wbWritedata,
  input  logic              wbRegWrite,
  input  logic              exMemRead,
  input  logic              exRegWrite,
  input  logic [IDX_W-1:0]  exWritereg,
  input  logic              flush,
  input  logic              stallCntClr,
  output logic [DATA_W-1:0] readdata1,
  output logic [DATA_W-1:0] readdata2,
  output logic              stall,
  output logic              bubble,
  output logic [CNT_W-1:0]  stallCnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic hz;

  rf8x16_bypass uRegFile (
    .clk     (clk),
    .rst     (rst),
    .rdIdx1  (rs),
    .rdIdx2  (rt),
    .wrIdx   (wbWritereg),
    .wrData  (wbWritedata),
    .wrEn    (wbRegWrite),
    .rdData1 (readdata1),
    .rdData2 (readdata2)
  );

  // Load-use hazard: a load in EX targets a register the ID instruction reads.
  // A flush kills the ID instruction, so it is bubbled but never stalled.
  always_comb begin
    hz     = exMemRead & exRegWrite &
             ((rsUsed & (rs == exWritereg)) | (rtUsed & (rt == exWritereg)));
    stall  = hz & ~flush;
    bubble = hz | flush;
  end

  // Stall counter: reset, then clear, then saturating increment on stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      stallCnt <= '0;
    end else if (stallCntClr) begin
      stallCnt <= '0;
    end else if (stall && (stallCnt != CNT_MAX)) begin
      stallCnt <= stallCnt + CNT_ONE;
    end
  end

endmodule

// File: doc/decode_hazard_regfile.md
Name: decode_hazard_regfile

Overview:
Decode-stage register file with hazard logic. It sits directly upstream of the ID/EX pipeline register and supplies its readdata1/readdata2 operands. It also drives the stall and bubble controls that freeze IF/ID and zero the control inputs of ID/EX. The storage is an 8 x 16-bit register file written back from WB, with same-cycle write-through bypass and load-use hazard detection against the instruction currently in EX.

Parameters:
DATA_W, 16, register and data width
NREG, 8, number of architectural registers
IDX_W, 3, register index width (log2 NREG)
CNT_W, 16, width of the stall-cycle performance counter

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
rs  in  IDX_W  source register 1 index of the instruction in ID
rt  in  IDX_W  source register 2 index of the instruction in ID
rsUsed  in  1  instruction in ID actually reads rs
rtUsed  in  1  instruction in ID actually reads rt
wbWritereg  in  IDX_W  WB-stage destination index
wbWritedata  in  DATA_W  WB-stage result
wbRegWrite  in  1  WB-stage write enable
exMemRead  in  1  memRead currently held in ID/EX (instruction in EX is a load)
exRegWrite  in  1  regWrite currently held in ID/EX
exWritereg  in  IDX_W  writereg currently held in ID/EX
flush  in  1  taken branch/jump resolved in EX; kill the ID instruction
stallCntClr  in  1  synchronous clear of stall counter
readdata1  out  DATA_W  operand for rs (feeds ID/EX readdata1)
readdata2  out  DATA_W  operand for rt (feeds ID/EX readdata2)
stall  out  1  hold PC and IF/ID this cycle
bubble  out  1  force all ID/EX control inputs to 0 this cycle
stallCnt  out  CNT_W  saturating count of stall cycles

Behaviour:
- Reset (rst high at clock edge):
  - All NREG registers clear to 0x0000.
  - stallCnt clears to 0.
  - rst has priority over a simultaneous WB write: the register stays 0.
  - stall and bubble are combinational, so they follow the reset state of their inputs; no reset value is needed.
- Register write: on a rising edge with wbRegWrite=1 and rst=0, regs[wbWritereg] <= wbWritedata.
  - R0 is an ordinary register, not hardwired to zero.
- Read is combinational with zero latency:
  - readdata1 = (wbRegWrite && wbWritereg==rs) ? wbWritedata : regs[rs].
  - readdata2 is the same rule with rt.
  - The bypass applies regardless of rsUsed/rtUsed.
  - When rs==rt, both outputs return the same value, including the bypassed value.
- Load-use hazard:
  - hz = exMemRead & exRegWrite & ((rsUsed & rs==exWritereg) | (rtUsed & rt==exWritereg)).
- Stall and bubble:
  - stall = hz & ~flush. A flush kills the ID instruction, so there is nothing to stall.
  - bubble = hz | flush.
  - A stall lasts exactly one cycle per load-use pair. The next cycle the load has moved to MEM (ID/EX holds the bubble, exMemRead=0), so hz deasserts.
  - Forwarding from MEM/WB into EX is handled elsewhere.
- stallCnt, in priority order on each edge:
  - rst clears it.
  - Otherwise stallCntClr clears it.
  - Otherwise it increments by 1 when stall=1.
  - It saturates at 2^CNT_W-1; it never wraps.
  - stallCntClr and stall in the same cycle: the result is 0.
- No state is held other than the register array and stallCnt.

Decomposition:
- Shared package: DATA_W, NREG, IDX_W constants.
- One sub-module, rf8x16_bypass: the storage array, the write port and the two bypassed read ports.
- The hazard logic and counter stay in the top level.

Test Plan:
- Reset then read all indices → readdata1/readdata2 = 0x0000 for rs,rt = 0..7; stallCnt = 0.
- Write R3=0xBEEF (wbRegWrite=1), next cycle rs=3 → readdata1 = 0xBEEF. In the same cycle as the write, with rs=3 and rt=3, both outputs = 0xBEEF via the bypass.
- exMemRead=1, exRegWrite=1, exWritereg=5, rt=5, rtUsed=1 → stall=1, bubble=1, stallCnt increments to 1. The same case with rtUsed=0 → stall=0.
- Hazard condition plus flush=1 → stall=0, bubble=1; stallCnt unchanged.
- Preload stallCnt to 0xFFFE and hold the hazard for 3 cycles → stallCnt reads 0xFFFF and stays there. stallCntClr=1 with stall=1 → 0.
- rst asserted mid-run together with wbRegWrite=1 to R2=0x1234 → R2 reads 0x0000 after the edge and stallCnt = 0.
